// File: rtl/uart_cmd_pkg.sv
// Shared codes and state encodings for the UART command engine.
package uart_cmd_pkg;

  localparam logic [7:0] TAG_WRITE_SLOT    = 8'h00;
  localparam logic [7:0] TAG_COMMIT        = 8'h01;
  localparam logic [7:0] TAG_GET_FRAME_CTR = 8'h02;
  localparam logic [7:0] TAG_READ_SLOT     = 8'h03;

  localparam logic [7:0] RSP_OK  = 8'h00;
  localparam logic [7:0] RSP_TAG = 8'h01;
  localparam logic [7:0] RSP_LEN = 8'h02;
  localparam logic [7:0] RSP_TMO = 8'h03;
  localparam logic [7:0] RSP_SUM = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_PAYLOAD,
    ST_GET_SUM,
    ST_EXEC,
    ST_WAIT_CASTER,
    ST_TX
  } state_t;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_SEND,
    TS_GAP
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Response byte sequencer: shifts out a loaded byte string LSB-first under the UART busy handshake.
//  state   | meaning
//  TS_IDLE | waiting for load
//  TS_SEND | next byte pending; strobe as soon as the transmitter is free
//  TS_GAP  | one cycle after a strobe, before busy is trusted
module uart_cmd_tx_seq
  import uart_cmd_pkg::*;
#(
  parameter int NBYTES = 13,
  parameter int CW     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NBYTES*8-1:0] data,
  input  logic [CW-1:0]       count,
  input  logic                uart_tx_busy,
  output logic                uart_tx_start,
  output logic [7:0]          uart_tx_byte,
  output logic                done
);

  tx_state_t           ts;
  logic [NBYTES*8-1:0] shreg;
  logic [CW-1:0]       remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts            <= TS_IDLE;
      shreg         <= '0;
      remaining     <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_byte  <= 8'h00;
      done          <= 1'b0;
    end else begin
      uart_tx_start <= 1'b0;
      done          <= 1'b0;
      case (ts)
        TS_IDLE: if (load) begin
          shreg     <= data;
          remaining <= count;
          ts        <= TS_SEND;
        end
        TS_SEND: if (!uart_tx_busy) begin
          uart_tx_start <= 1'b1;
          uart_tx_byte  <= shreg[7:0];
          shreg         <= {8'h00, shreg[NBYTES*8-1:8]};
          remaining     <= remaining - 1'b1;
          ts            <= TS_GAP;
        end
        TS_GAP: begin
          if (remaining == '0) begin
            done <= 1'b1;
            ts   <= TS_IDLE;
          end else begin
            ts <= TS_SEND;
          end
        end
        default: ts <= TS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// Host command processor: framed packet parser, shadow/active slot set, frame counter.
// Optional slot readback (tag 03) is built when UART_CMD_READBACK_EN is defined.
//  state          | meaning
//  ST_IDLE        | waiting for a tag byte
//  ST_GET_LEN     | waiting for the length byte
//  ST_PAYLOAD     | consuming len payload bytes
//  ST_GET_SUM     | waiting for the XOR checksum
//  ST_EXEC        | decode and act on a checked packet
//  ST_WAIT_CASTER | caster asked to stop; commit when it reports ready
//  ST_TX          | response in flight
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int SLOT_W         = 96,
  parameter int MAX_PAYLOAD    = 16,
  parameter int FRAME_CTR_W    = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter logic [NUM_SLOTS*SLOT_W-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_rx_valid,
  input  logic [7:0]                  uart_rx_byte,
  input  logic                        uart_tx_busy,
  output logic                        uart_tx_start,
  output logic [7:0]                  uart_tx_byte,
  input  logic                        frame_done,
  input  logic                        caster_ready,
  output logic                        stop_caster,
  output logic [NUM_SLOTS*SLOT_W-1:0] active_slots,
  output logic                        commit_pulse
);

  localparam int SB        = SLOT_W / 8;
  localparam int FB        = FRAME_CTR_W / 8;
  localparam int TX_BYTES  = 1 + ((FRAME_CTR_W > SLOT_W) ? FB : SB);
  localparam int TXW       = TX_BYTES * 8;
  localparam int CW        = $clog2(TX_BYTES + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BUF_BYTES = 1 + SB;
  localparam logic [7:0]    WR_LEN   = 8'(BUF_BYTES);
  localparam logic [7:0]    MAXP8    = 8'(MAX_PAYLOAD);
  localparam logic [7:0]    NS8      = 8'(NUM_SLOTS);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  state_t                        state;
  logic [7:0]                    tag, len, idx, sum;
  logic                          len_err;
  logic [BUF_BYTES*8-1:0]        pbuf;
  logic [TW-1:0]                 tmo;
  logic [NUM_SLOTS*SLOT_W-1:0]   shadow;
  logic [FRAME_CTR_W-1:0]        frame_ctr;
  logic                          tx_load, tx_done;
  logic [TXW-1:0]                tx_data;
  logic [CW-1:0]                 tx_cnt;
  logic [7:0]                    slot_id;
  logic                          slot_ok;

  assign slot_id = pbuf[7:0];
  assign slot_ok = slot_id < NS8;

`ifdef UART_CMD_READBACK_EN
  logic [SLOT_W-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (slot_id == 8'(k)) rd_data = shadow[k*SLOT_W +: SLOT_W];
  end
`endif

  task automatic send(input logic [TXW-1:0] d, input logic [CW-1:0] n);
    tx_data <= d;
    tx_cnt  <= n;
    tx_load <= 1'b1;
    state   <= ST_TX;
  endtask

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tag          <= 8'h00;
      len          <= 8'h00;
      idx          <= 8'h00;
      sum          <= 8'h00;
      len_err      <= 1'b0;
      pbuf         <= '0;
      tmo          <= '0;
      shadow       <= RESET_VALUE;
      active_slots <= RESET_VALUE;
      frame_ctr    <= '0;
      stop_caster  <= 1'b0;
      commit_pulse <= 1'b0;
      tx_load      <= 1'b0;
      tx_data      <= '0;
      tx_cnt       <= '0;
    end else begin
      tx_load      <= 1'b0;
      commit_pulse <= 1'b0;
      if (commit_pulse) stop_caster <= 1'b0;
      if (frame_done && !(&frame_ctr)) frame_ctr <= frame_ctr + 1'b1;

      case (state)
        ST_IDLE: if (uart_rx_valid) begin
          tag     <= uart_rx_byte;
          sum     <= uart_rx_byte;
          len_err <= 1'b0;
          tmo     <= TMO_LOAD;
          state   <= ST_GET_LEN;
        end
        ST_GET_LEN, ST_PAYLOAD, ST_GET_SUM: begin
          if (uart_rx_valid) begin
            tmo <= TMO_LOAD;
            sum <= sum ^ uart_rx_byte;
            if (state == ST_GET_LEN) begin
              len   <= uart_rx_byte;
              idx   <= 8'h00;
              state <= (uart_rx_byte == 8'h00) ? ST_GET_SUM : ST_PAYLOAD;
            end else if (state == ST_PAYLOAD) begin
              // only the bytes a valid command can use are kept
              for (int b = 0; b < BUF_BYTES; b++)
                if (idx == 8'(b)) pbuf[b*8 +: 8] <= uart_rx_byte;
              if (idx >= MAXP8) len_err <= 1'b1;
              idx <= idx + 8'd1;
              if (idx + 8'd1 == len) state <= ST_GET_SUM;
            end else begin
              if (uart_rx_byte != sum) send(TXW'(RSP_SUM), CW'(1));
              else                     state <= ST_EXEC;
            end
          end else if (tmo == TW'(1)) begin
            send(TXW'(RSP_TMO), CW'(1));
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        ST_EXEC: begin
          case (tag)
            TAG_WRITE_SLOT:
              if (len != WR_LEN || len_err || !slot_ok) begin
                send(TXW'(RSP_LEN), CW'(1));
              end else begin
                for (int k = 0; k < NUM_SLOTS; k++)
                  if (slot_id == 8'(k)) shadow[k*SLOT_W +: SLOT_W] <= pbuf[8 +: SLOT_W];
                send(TXW'(RSP_OK), CW'(1));
              end
            TAG_COMMIT:
              if (len != 8'h00) begin
                send(TXW'(RSP_LEN), CW'(1));
              end else begin
                stop_caster <= 1'b1;
                state       <= ST_WAIT_CASTER;
              end
            TAG_GET_FRAME_CTR:
              if (len != 8'h00) begin
                send(TXW'(RSP_LEN), CW'(1));
              end else begin
                send(TXW'({frame_ctr, RSP_OK}), CW'(1 + FB));
                // a frame ending in the snapshot cycle belongs to the next read
                frame_ctr <= FRAME_CTR_W'(frame_done);
              end
`ifdef UART_CMD_READBACK_EN
            TAG_READ_SLOT:
              if (len != 8'h01 || !slot_ok) send(TXW'(RSP_LEN), CW'(1));
              else                          send(TXW'({rd_data, RSP_OK}), CW'(1 + SB));
`else
            TAG_READ_SLOT: send(TXW'(RSP_TAG), CW'(1));
`endif
            default: send(TXW'(RSP_TAG), CW'(1));
          endcase
        end
        ST_WAIT_CASTER: if (caster_ready) begin
          active_slots <= shadow;
          commit_pulse <= 1'b1;
          send(TXW'(RSP_OK), CW'(1));
        end
        ST_TX: if (tx_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_cmd_tx_seq #(
    .NBYTES (TX_BYTES),
    .CW     (CW)
  ) u_tx_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (tx_load),
    .data          (tx_data),
    .count         (tx_cnt),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_start (uart_tx_start),
    .uart_tx_byte  (uart_tx_byte),
    .done          (tx_done)
  );

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Randomized bench for uart_cmd_engine against a packet-level reference model.
module tb_uart_cmd_engine;

  localparam int NS  = 8;
  localparam int SW  = 96;
  localparam int TMO = 200;
  localparam logic [NS*SW-1:0] RV = {24{32'hA5C3_0F1E}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic frame_done = 1'b0;
  logic caster_ready = 1'b0;
  logic uart_tx_busy, uart_tx_start, stop_caster, commit_pulse;
  logic [7:0] uart_tx_byte;
  logic [NS*SW-1:0] active_slots;

  int n_chk = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  logic [7:0] got[$];
  logic [SW-1:0] m_shadow[NS];
  logic [SW-1:0] m_active[NS];
  int unsigned m_ctr;

  always #5 clk = ~clk;
  assign uart_tx_busy = (busy_cnt != 0);

  uart_cmd_engine #(
    .NUM_SLOTS(NS), .SLOT_W(SW), .MAX_PAYLOAD(16), .FRAME_CTR_W(24),
    .TIMEOUT_CYCLES(TMO), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_valid(uart_rx_valid), .uart_rx_byte(uart_rx_byte),
    .uart_tx_busy(uart_tx_busy), .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
    .frame_done(frame_done), .caster_ready(caster_ready), .stop_caster(stop_caster),
    .active_slots(active_slots), .commit_pulse(commit_pulse)
  );

  task automatic chk(input string tag, input logic [767:0] o, input logic [767:0] e);
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, o, e);
    end
  endtask

  // transmitter model: captures strobes and holds busy for a random time
  always @(negedge clk) begin
    if (uart_tx_start) begin
      chk("tx_strobe_while_busy", {767'd0, uart_tx_busy}, 768'd0);
      got.push_back(uart_tx_byte);
      busy_cnt = $urandom_range(1, 5);
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
  end

  function automatic logic [NS*SW-1:0] flat_active();
    logic [NS*SW-1:0] r;
    for (int k = 0; k < NS; k++) r[k*SW +: SW] = m_active[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_shadow[k] = RV[k*SW +: SW];
      m_active[k] = RV[k*SW +: SW];
    end
    m_ctr = 0;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_byte  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic fd_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_done = 1'b1;
      @(negedge clk); frame_done = 1'b0;
      if (m_ctr != 32'hFF_FFFF) m_ctr++;
    end
  endtask

  // expected response bytes and model side effects of one packet
  task automatic model(input logic [7:0] tag, input logic [7:0] pl[$], input bit sum_ok,
                       input bit fd_snap, output logic [7:0] e[$]);
    logic [SW-1:0] d;
    int len;
    len = pl.size();
    e.delete();
    if (!sum_ok) e.push_back(8'hFF);
    else if (tag == 8'h00) begin
      if (len != 13 || pl[0] >= NS) e.push_back(8'h02);
      else begin
        for (int i = 0; i < 12; i++) d[i*8 +: 8] = pl[i+1];
        m_shadow[pl[0]] = d;
        e.push_back(8'h00);
      end
    end else if (tag == 8'h01) begin
      if (len != 0) e.push_back(8'h02);
      else begin
        for (int k = 0; k < NS; k++) m_active[k] = m_shadow[k];
        e.push_back(8'h00);
      end
    end else if (tag == 8'h02) begin
      if (len != 0) e.push_back(8'h02);
      else begin
        e.push_back(8'h00);
        for (int i = 0; i < 3; i++) e.push_back(8'((m_ctr >> (8*i)) & 32'hFF));
        m_ctr = fd_snap ? 1 : 0;
      end
    end else if (tag == 8'h03) begin
`ifdef UART_CMD_READBACK_EN
      if (len != 1 || pl[0] >= NS) e.push_back(8'h02);
      else begin
        e.push_back(8'h00);
        for (int i = 0; i < 12; i++) e.push_back(m_shadow[pl[0]][i*8 +: 8]);
      end
`else
      e.push_back(8'h01);
`endif
    end else e.push_back(8'h01);
  endtask

  task automatic expect_rsp(input string nm, input logic [7:0] e[$]);
    int t = 0;
    while (got.size() < e.size() && t < 3000) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    chk({nm, "_nbytes"}, 768'(got.size()), 768'(e.size()));
    foreach (e[i]) if (i < got.size()) chk(nm, {760'd0, got[i]}, {760'd0, e[i]});
    got.delete();
  endtask

  task automatic run_pkt(input string nm, input logic [7:0] tag, input logic [7:0] pl[$],
                         input bit bad_sum, input bit fd_snap, input int gap);
    logic [7:0] s, len;
    logic [7:0] e[$];
    len = 8'(pl.size());
    s = tag ^ len;
    foreach (pl[i]) s ^= pl[i];
    if (bad_sum) s ^= 8'h01;
    put(tag);
    repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
    put(len);
    foreach (pl[i]) begin
      repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
      put(pl[i]);
    end
    repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
    put(s);
    if (fd_snap) begin
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
    end
    model(tag, pl, !bad_sum, fd_snap, e);
    expect_rsp(nm, e);
    chk({nm, "_active"}, 768'(active_slots), 768'(flat_active()));
  endtask

  task automatic mk_write(input logic [7:0] slot, input logic [SW-1:0] d, output logic [7:0] pl[$]);
    pl.delete();
    pl.push_back(slot);
    for (int i = 0; i < 12; i++) pl.push_back(d[i*8 +: 8]);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] none[$];
    logic [7:0] e[$];
    logic [SW-1:0] d;
    int t, kind;

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_start", 768'(uart_tx_start), 768'd0);
    chk("rst_tx_byte", 768'(uart_tx_byte), 768'd0);
    chk("rst_stop", 768'(stop_caster), 768'd0);
    chk("rst_commit", 768'(commit_pulse), 768'd0);
    chk("rst_active", 768'(active_slots), 768'(RV));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write slot 2 then a commit held off by the caster
    mk_write(8'd2, 96'h0C0B0A09_08070605_04030201, pl);
    run_pkt("write2", 8'h00, pl, 0, 0, -1);
    put(8'h01); put(8'h00); put(8'h01);
    repeat (3) @(negedge clk);
    chk("stop_caster_hi", 768'(stop_caster), 768'd1);
    repeat (5) @(negedge clk);
    chk("commit_not_yet", 768'(commit_pulse), 768'd0);
    chk("active_held", 768'(active_slots), 768'(flat_active()));
    chk("no_rsp_before_commit", 768'(got.size()), 768'd0);
    caster_ready = 1'b1;
    t = 0;
    while (!commit_pulse && t < 50) begin @(negedge clk); t++; end
    chk("commit_seen", 768'(commit_pulse), 768'd1);
    chk("commit_slot2", 768'(active_slots[2*SW +: SW]), 768'(96'h0C0B0A09_08070605_04030201));
    chk("stop_during_pulse", 768'(stop_caster), 768'd1);
    @(negedge clk);
    chk("commit_one_cycle", 768'(commit_pulse), 768'd0);
    chk("stop_dropped", 768'(stop_caster), 768'd0);
    caster_ready = 1'b0;
    model(8'h01, none, 1, 0, e);
    expect_rsp("commit", e);
    chk("commit_active", 768'(active_slots), 768'(flat_active()));

    // readback (or unknown-tag answer without the option)
    pl.delete(); pl.push_back(8'd2);
    run_pkt("readback2", 8'h03, pl, 0, 0, -1);

    // error responses
    mk_write(8'd2, 96'hDEAD_BEEF_0000_1111_2222_3333, pl);
    run_pkt("bad_sum", 8'h00, pl, 1, 0, -1);
    mk_write(8'd8, 96'h1, pl);
    run_pkt("slot8", 8'h00, pl, 0, 0, -1);
    pl.delete();
    for (int i = 0; i < 32; i++) pl.push_back(8'($urandom));
    run_pkt("len32", 8'h00, pl, 0, 0, -1);
    pl.delete(); pl.push_back(8'h00);
    run_pkt("commit_len1", 8'h01, pl, 0, 0, -1);
    run_pkt("tag_unknown", 8'h7E, none, 0, 0, -1);
    pl.delete(); pl.push_back(8'd2);
    run_pkt("readback_after_err", 8'h03, pl, 0, 0, -1);

    // frame counter and the snapshot-cycle boundary
    fd_pulses(10);
    run_pkt("frame10", 8'h02, none, 0, 1, -1);
    run_pkt("frame_snap", 8'h02, none, 0, 0, -1);

    // inter-byte timeout
    put(8'h00); put(8'h0D);
    t = 0;
    while (got.size() == 0 && t < TMO + 100) begin @(negedge clk); t++; end
    chk("tmo_window", 768'((t >= TMO - 3) && (t <= TMO + 10)), 768'd1);
    e.delete(); e.push_back(8'h03);
    expect_rsp("timeout", e);
    mk_write(8'd5, 96'h5555_AAAA_1234_5678_9ABC_DEF0, pl);
    run_pkt("slow_write", 8'h00, pl, 0, 0, TMO - 20);

    // randomized traffic
    caster_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 7);
      d = {$urandom, $urandom, $urandom};
      case (kind)
        0, 1: begin mk_write(8'($urandom_range(0, NS-1)), d, pl); run_pkt("r_write", 8'h00, pl, 0, 0, -1); end
        2: begin
          mk_write(8'($urandom_range(NS, 255)), d, pl);
          if ($urandom_range(0, 1) == 1) void'(pl.pop_back());
          run_pkt("r_badwrite", 8'h00, pl, 0, 0, -1);
        end
        3: begin mk_write(8'($urandom_range(0, NS-1)), d, pl); run_pkt("r_badsum", 8'h00, pl, 1, 0, -1); end
        4: run_pkt("r_commit", 8'h01, none, 0, 0, -1);
        5: begin fd_pulses($urandom_range(0, 4)); run_pkt("r_frame", 8'h02, none, 0, 0, -1); end
        6: begin
          pl.delete();
          for (int i = 0; i < $urandom_range(0, 3); i++) pl.push_back(8'($urandom));
          run_pkt("r_unknown", 8'($urandom_range(4, 255)), pl, 0, 0, -1);
        end
        default: begin pl.delete(); pl.push_back(8'($urandom_range(0, 9))); run_pkt("r_read", 8'h03, pl, 0, 0, -1); end
      endcase
    end
    run_pkt("r_commit_final", 8'h01, none, 0, 0, -1);

    // reset during a commit and during a packet
    caster_ready = 1'b0;
    put(8'h01); put(8'h00); put(8'h01);
    repeat (4) @(negedge clk);
    chk("stop_before_rst", 768'(stop_caster), 768'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stop_drop", 768'(stop_caster), 768'd0);
    chk("rst_active_image", 768'(active_slots), 768'(RV));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    got.delete();
    put(8'h00); put(8'h0D); put(8'h03);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    caster_ready = 1'b1;
    mk_write(8'd6, 96'hCAFE_F00D_0102_0304_0506_0708, pl);
    run_pkt("post_rst_write", 8'h00, pl, 0, 0, -1);
    run_pkt("post_rst_commit", 8'h01, none, 0, 0, -1);
    pl.delete(); pl.push_back(8'd3);
    run_pkt("post_rst_read", 8'h03, pl, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
